// File: rtl/north_gdma_pkg.sv
// Shared definitions for the north GDMA sender path.
// Holds the AXI encodings used by the address and data stages, the write-data
// FSM state type and the default data-pattern seed.
package north_gdma_pkg;

  localparam logic [1:0]  BURST_INCR = 2'b01;
  localparam logic [2:0]  AXSIZE_4B  = 3'b010;
  localparam logic [1:0]  RESP_OKAY  = 2'b00;

  localparam logic [31:0] PATTERN_SEED_DEFAULT = 32'hA5A5_0000;

  localparam int unsigned OUTST_W = 9;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DATA = 1'b1
  } wr_state_e;

endpackage

// File: rtl/north_len_fifo.sv
// Synchronous FIFO holding burst lengths between the AW and W channels.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   flush        empties the FIFO (takes priority over push/pop)
//   push, din    write request and data; ignored when full and not popping
//   pop, dout    read request and head entry (dout valid while !empty)
//   empty, full  occupancy flags
//   count        current number of entries
//   almost_full  registered, high when count >= DEPTH-1
module north_len_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] AF_CNT   = (PTR_W+1)'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             af_q, af_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop  = pop && (count_q != '0);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    do_push = push && ((count_q != FULL_CNT) || do_pop);

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end

    af_d = (count_d >= AF_CNT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      af_q     <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      af_q     <= af_d;
    end
  end

  assign dout        = mem_q[rd_ptr_q];
  assign empty       = (count_q == '0);
  assign full        = (count_q == FULL_CNT);
  assign count       = count_q;
  assign almost_full = af_q;

endmodule

// File: rtl/north_wrdata.sv
// AXI4 W/B stage of the north GDMA sender path.
// Records the awlen of each accepted AW, emits the matching W beats carrying
// PATTERN_SEED + word index, tracks outstanding B responses and raises
// gdma_data_done once the job is fully written and acknowledged.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   op_start              job-start pulse (flushes and re-arms the stage)
//   gdma_addr_done        address stage has issued every AW of the job
//   aw_fire, aw_len       AW handshake and its awlen
//   aw_hold               length FIFO nearly full, gates awready upstream
//   gdma_ddr_wr*          AXI W channel (data/strb/last/valid/ready)
//   gdma_ddr_wrb*         AXI B channel (bresp/bvalid/bready)
//   gdma_data_done        job complete and acknowledged
//   resp_err, ovf_err     sticky error flags, cleared by op_start
module north_wrdata
  import north_gdma_pkg::*;
#(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned LEN_FIFO_DEPTH = 8,
  parameter logic [31:0] PATTERN_SEED   = PATTERN_SEED_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                op_start,
  input  logic                gdma_addr_done,
  input  logic                aw_fire,
  input  logic [7:0]          aw_len,
  output logic                aw_hold,
  output logic [DATA_W-1:0]   gdma_ddr_wrdata,
  output logic [DATA_W/8-1:0] gdma_ddr_wrstrb,
  output logic                gdma_ddr_wrlast,
  output logic                gdma_ddr_wrvalid,
  input  logic                gdma_ddr_wrready,
  input  logic [1:0]          gdma_ddr_wrbresp,
  input  logic                gdma_ddr_wrbvalid,
  output logic                gdma_ddr_wrbready,
  output logic                gdma_data_done,
  output logic                resp_err,
  output logic                ovf_err
);

  localparam int unsigned CNT_W = $clog2(LEN_FIFO_DEPTH) + 1;

  wr_state_e            state_q, state_d;
  logic [7:0]           beat_cnt_q, beat_cnt_d;
  logic [31:0]          word_idx_q, word_idx_d;
  logic [OUTST_W-1:0]   outst_q, outst_d;
  logic                 bready_q, bready_d;
  logic                 done_q, done_d;
  logic                 resp_err_q, resp_err_d;
  logic                 ovf_err_q, ovf_err_d;

  logic                 fifo_push;
  logic [7:0]           fifo_head;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic [CNT_W-1:0]     fifo_count;
  logic                 fifo_af;

  logic                 w_hs, last_hs, b_hs, push_drop;

  north_len_fifo #(
    .WIDTH (8),
    .DEPTH (LEN_FIFO_DEPTH)
  ) u_len_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (op_start),
    .push        (fifo_push),
    .din         (aw_len),
    .pop         (last_hs),
    .dout        (fifo_head),
    .empty       (fifo_empty),
    .full        (fifo_full),
    .count       (fifo_count),
    .almost_full (fifo_af)
  );

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (op_start) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (!fifo_empty || fifo_push) state_d = ST_DATA;
        // Another length already queued, or arriving now, continues without a bubble.
        ST_DATA: if (last_hs && !((fifo_count > CNT_W'(1)) || fifo_push)) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM: outputs, all from registers so wrlast never depends on wrready
  always_comb begin
    gdma_ddr_wrvalid = (state_q == ST_DATA);
    gdma_ddr_wrlast  = (state_q == ST_DATA) && (beat_cnt_q == fifo_head);
    gdma_ddr_wrdata  = DATA_W'(PATTERN_SEED) + DATA_W'(word_idx_q);
    gdma_ddr_wrstrb  = '1;
  end

  always_comb begin
    fifo_push = aw_fire && !op_start;
    w_hs      = gdma_ddr_wrvalid && gdma_ddr_wrready;
    last_hs   = w_hs && gdma_ddr_wrlast;
    b_hs      = gdma_ddr_wrbvalid && bready_q;
    push_drop = fifo_push && fifo_full && !last_hs;

    bready_d   = 1'b1;
    beat_cnt_d = beat_cnt_q;
    word_idx_d = word_idx_q;
    outst_d    = outst_q;
    done_d     = done_q;
    resp_err_d = resp_err_q;
    ovf_err_d  = ovf_err_q;

    if (op_start) begin
      beat_cnt_d = '0;
      word_idx_d = '0;
      outst_d    = '0;
      done_d     = 1'b0;
      resp_err_d = 1'b0;
      ovf_err_d  = 1'b0;
    end else begin
      if (last_hs) begin
        beat_cnt_d = '0;
      end else if (w_hs) begin
        beat_cnt_d = beat_cnt_q + 8'd1;
      end
      if (w_hs) begin
        word_idx_d = word_idx_q + 32'd1;
      end

      // A B with nothing outstanding is flagged and never underflows the count.
      case ({last_hs, b_hs})
        2'b10:   outst_d = outst_q + OUTST_W'(1);
        2'b01:   outst_d = (outst_q == '0) ? '0 : outst_q - OUTST_W'(1);
        default: outst_d = outst_q;
      endcase

      if (b_hs && ((gdma_ddr_wrbresp != RESP_OKAY) || (outst_q == '0))) begin
        resp_err_d = 1'b1;
      end
      if (push_drop) begin
        ovf_err_d = 1'b1;
      end
      if (gdma_addr_done && fifo_empty && (state_q == ST_IDLE) && (outst_q == '0)) begin
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q <= '0;
      word_idx_q <= '0;
      outst_q    <= '0;
      bready_q   <= 1'b0;
      done_q     <= 1'b1;
      resp_err_q <= 1'b0;
      ovf_err_q  <= 1'b0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      word_idx_q <= word_idx_d;
      outst_q    <= outst_d;
      bready_q   <= bready_d;
      done_q     <= done_d;
      resp_err_q <= resp_err_d;
      ovf_err_q  <= ovf_err_d;
    end
  end

  assign aw_hold           = fifo_af;
  assign gdma_ddr_wrbready = bready_q;
  assign gdma_data_done    = done_q;
  assign resp_err          = resp_err_q;
  assign ovf_err           = ovf_err_q;

endmodule

// File: tb/tb_north_wrdata.sv
// Scoreboard bench for north_wrdata: the stimulus side pushes the expected W
// beats (seed + running word number, last flag on the final beat of each
// awlen+1 burst) and a negedge monitor pops and compares every W handshake.
module tb_north_wrdata;
  import north_gdma_pkg::*;

  localparam int unsigned DATA_W = 32;
  localparam logic [31:0] SEED   = 32'hA5A5_0000;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              op_start;
  logic              gdma_addr_done;
  logic              aw_fire;
  logic [7:0]        aw_len;
  logic              aw_hold;
  logic [DATA_W-1:0] wrdata;
  logic [3:0]        wrstrb;
  logic              wrlast;
  logic              wrvalid;
  logic              wrready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic              done;
  logic              resp_err;
  logic              ovf_err;

  always #5 clk = ~clk;

  north_wrdata #(
    .DATA_W         (DATA_W),
    .LEN_FIFO_DEPTH (8),
    .PATTERN_SEED   (SEED)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .op_start          (op_start),
    .gdma_addr_done    (gdma_addr_done),
    .aw_fire           (aw_fire),
    .aw_len            (aw_len),
    .aw_hold           (aw_hold),
    .gdma_ddr_wrdata   (wrdata),
    .gdma_ddr_wrstrb   (wrstrb),
    .gdma_ddr_wrlast   (wrlast),
    .gdma_ddr_wrvalid  (wrvalid),
    .gdma_ddr_wrready  (wrready),
    .gdma_ddr_wrbresp  (bresp),
    .gdma_ddr_wrbvalid (bvalid),
    .gdma_ddr_wrbready (bready),
    .gdma_data_done    (done),
    .resp_err          (resp_err),
    .ovf_err           (ovf_err)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       mon_e;
  logic [31:0] model_word;
  int          n_checks = 0;
  int          n_fails  = 0;
  int          beats_seen = 0;
  int          lasts_seen = 0;
  int          valid_rises = 0;
  int          rdy_mode = 0;
  int          pat_idx = 0;
  logic        stall_prev = 1'b0;
  logic        prev_valid = 1'b0;
  logic [31:0] held_data;
  logic        held_last;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fails++;
    $display("FAIL %s: actual=timeout required=event", name);
  endtask

  // W ready driver: 0 always ready, 1 random, 2 never, 3 repeating 1,0,0,1
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       wrready = 1'b1;
      1:       wrready = 1'($urandom_range(0, 1));
      2:       wrready = 1'b0;
      default: begin
        wrready = ((pat_idx % 4) == 0) || ((pat_idx % 4) == 3);
        pat_idx++;
      end
    endcase
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (wrvalid && !prev_valid) valid_rises++;
      if (stall_prev && wrvalid) begin
        check("stall_wrdata", wrdata, held_data);
        check("stall_wrlast", wrlast, held_last);
      end
      if (wrvalid && wrready) begin
        beats_seen++;
        check("wrstrb", wrstrb, 4'hF);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("FAIL unexpected_beat: actual=%0h required=no beat", wrdata);
        end else begin
          mon_e = exp_q.pop_front();
          check("wrdata", wrdata, mon_e.data);
          check("wrlast", wrlast, mon_e.last);
        end
        if (wrlast) lasts_seen++;
      end
      stall_prev = wrvalid && !wrready;
      held_data  = wrdata;
      held_last  = wrlast;
      prev_valid = wrvalid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job();
    gdma_addr_done = 1'b0;
    op_start = 1'b1;
    tick();
    op_start = 1'b0;
    model_word = 32'd0;
    check("done_cleared_by_start", done, 1'b0);
    check("resp_err_cleared_by_start", resp_err, 1'b0);
    check("ovf_err_cleared_by_start", ovf_err, 1'b0);
  endtask

  task automatic push_aw(input logic [7:0] len, input bit accept);
    aw_fire = 1'b1;
    aw_len  = len;
    if (accept) begin
      for (int i = 0; i <= int'(len); i++) begin
        exp_q.push_back('{data: SEED + model_word, last: (i == int'(len))});
        model_word++;
      end
    end
    tick();
    aw_fire = 1'b0;
  endtask

  task automatic push_wait(input logic [7:0] len);
    int n = 0;
    while (aw_hold && n < 3000) begin
      tick();
      n++;
    end
    if (aw_hold) timeout_fail("aw_hold_timeout");
    push_aw(len, 1'b1);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      timeout_fail("drain_timeout");
      exp_q.delete();
    end
    repeat (2) tick();
  endtask

  task automatic send_b(input logic [1:0] r);
    bvalid = 1'b1;
    bresp  = r;
    tick();
    bvalid = 1'b0;
    bresp  = 2'b00;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int l0, r0, b0, n, nb, acked, vcnt;
    rst_n = 1'b0;
    op_start = 1'b0;
    gdma_addr_done = 1'b0;
    aw_fire = 1'b0;
    aw_len = 8'd0;
    bresp = 2'b00;
    bvalid = 1'b0;
    wrready = 1'b1;
    model_word = 32'd0;

    // Reset values
    #12;
    check("rst_wrvalid", wrvalid, 1'b0);
    check("rst_wrlast", wrlast, 1'b0);
    check("rst_wrdata", wrdata, SEED);
    check("rst_bready", bready, 1'b0);
    check("rst_done", done, 1'b1);
    check("rst_resp_err", resp_err, 1'b0);
    check("rst_ovf_err", ovf_err, 1'b0);
    check("rst_aw_hold", aw_hold, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("bready_after_reset", bready, 1'b1);
    check("done_held_after_reset", done, 1'b1);

    // Single burst of 4 beats
    start_job();
    l0 = lasts_seen;
    push_aw(8'd3, 1'b1);
    wait_drain(100);
    check("single_lasts", lasts_seen - l0, 1);
    gdma_addr_done = 1'b1;
    tick();
    check("single_done_waits_b", done, 1'b0);
    send_b(RESP_OKAY);
    check("single_done_not_yet", done, 1'b0);
    tick();
    check("single_done_after_b", done, 1'b1);

    // Back-to-back 256-beat and 1-beat bursts
    start_job();
    r0 = valid_rises;
    l0 = lasts_seen;
    push_aw(8'd255, 1'b1);
    push_aw(8'd0, 1'b1);
    wait_drain(600);
    check("b2b_valid_rises", valid_rises - r0, 1);
    check("b2b_lasts", lasts_seen - l0, 2);
    gdma_addr_done = 1'b1;
    send_b(RESP_OKAY);
    repeat (2) tick();
    check("b2b_done_one_outstanding", done, 1'b0);
    send_b(RESP_OKAY);
    tick();
    check("b2b_done", done, 1'b1);

    // Backpressure 1,0,0,1
    start_job();
    rdy_mode = 3;
    pat_idx = 0;
    push_aw(8'd3, 1'b1);
    wait_drain(100);
    rdy_mode = 0;
    gdma_addr_done = 1'b1;
    send_b(RESP_OKAY);
    tick();
    check("bp_done", done, 1'b1);

    // FIFO full / overflow
    start_job();
    rdy_mode = 2;
    tick();
    for (int k = 1; k <= 8; k++) begin
      push_aw(8'($urandom_range(0, 3)), 1'b1);
      if (k == 6) check("hold_after_6", aw_hold, 1'b0);
      if (k == 7) check("hold_after_7", aw_hold, 1'b1);
    end
    check("ovf_before_9th", ovf_err, 1'b0);
    push_aw(8'd5, 1'b0);
    check("ovf_after_9th", ovf_err, 1'b1);
    check("hold_when_full", aw_hold, 1'b1);
    l0 = lasts_seen;
    rdy_mode = 0;
    wait_drain(500);
    check("full_bursts_drained", lasts_seen - l0, 8);
    check("hold_after_drain", aw_hold, 1'b0);
    gdma_addr_done = 1'b1;
    for (int k = 0; k < 8; k++) send_b(RESP_OKAY);
    tick();
    check("full_done", done, 1'b1);

    // Response errors
    start_job();
    push_aw(8'd1, 1'b1);
    wait_drain(100);
    gdma_addr_done = 1'b1;
    send_b(2'b10);
    check("slverr_sets_resp_err", resp_err, 1'b1);
    tick();
    check("slverr_done", done, 1'b1);
    start_job();
    send_b(RESP_OKAY);
    check("orphan_b_resp_err", resp_err, 1'b1);
    push_aw(8'd0, 1'b1);
    wait_drain(100);
    send_b(RESP_OKAY);
    gdma_addr_done = 1'b1;
    repeat (2) tick();
    check("orphan_counter_stayed_zero", done, 1'b1);

    // Randomized jobs
    for (int job = 0; job < 6; job++) begin
      start_job();
      rdy_mode = 1;
      nb = $urandom_range(1, 12);
      l0 = lasts_seen;
      for (int k = 0; k < nb; k++) begin
        if ($urandom_range(0, 9) == 0) push_wait(8'($urandom_range(16, 60)));
        else push_wait(8'($urandom_range(0, 7)));
        if ($urandom_range(0, 2) == 0) tick();
      end
      gdma_addr_done = 1'b1;
      acked = 0;
      n = 0;
      while (acked < nb && n < 6000) begin
        if (lasts_seen - l0 > acked) begin
          if (acked == nb - 1) check("rand_done_before_last_b", done, 1'b0);
          send_b(RESP_OKAY);
          acked++;
        end else begin
          tick();
        end
        n++;
      end
      if (acked < nb) timeout_fail("rand_b_timeout");
      wait_drain(100);
      rdy_mode = 0;
      check("rand_done", done, 1'b1);
      check("rand_resp_err", resp_err, 1'b0);
      check("rand_ovf_err", ovf_err, 1'b0);
    end

    // Reset during beat 2 of an 8-beat burst
    start_job();
    b0 = beats_seen;
    push_aw(8'd7, 1'b1);
    n = 0;
    while (beats_seen < b0 + 1 && n < 50) begin
      tick();
      n++;
    end
    if (beats_seen < b0 + 1) timeout_fail("reset_burst_start_timeout");
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("async_rst_wrvalid", wrvalid, 1'b0);
    check("async_rst_done", done, 1'b1);
    check("async_rst_bready", bready, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    vcnt = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (wrvalid) vcnt++;
    end
    check("quiet_after_reset", vcnt, 0);
    check("done_after_reset", done, 1'b1);
    start_job();
    push_aw(8'd2, 1'b1);
    wait_drain(100);
    gdma_addr_done = 1'b1;
    send_b(RESP_OKAY);
    tick();
    check("post_reset_job_done", done, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
